// File: rtl/hazard_fwd_scoreboard.sv
// Scoreboard-based hazard unit: tracks in-flight writers per post-ID stage and derives
// EX operand bypass, MEM-MEM store-data bypass, load-use stall and saturating perf counters.
module hazard_fwd_scoreboard #(
  parameter int AW         = 4,
  parameter int DW         = 16,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MEM_MEM    = 1,
  localparam int SW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs,
  input  logic [AW-1:0]       id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_regwrite,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                flush,
  input  logic [DEPTH*DW-1:0] stage_result,
  input  logic [DW-1:0]       rf_rs,
  input  logic [DW-1:0]       rf_rt,
  output logic                stall,
  output logic [SW-1:0]       fwd_rs_sel,
  output logic [SW-1:0]       fwd_rt_sel,
  output logic [DW-1:0]       fwd_rs_data,
  output logic [DW-1:0]       fwd_rt_data,
  output logic                fwd_mem_rt,
  output logic [15:0]         stall_count,
  output logic [15:0]         fwd_count
);

  logic [DEPTH-1:0] v_q, rw_q, mr_q;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rs_p0, rt_p0, rt_p1;
  logic             mw_p0, mw_p1;
  logic [DEPTH-1:1] wr_rs, wr_rt;
  logic [DEPTH-1:0] wr_id_rs, wr_id_rt;
  logic             rs_haz, rt_haz, issue, fwd_any;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    wr_rs    = '0;
    wr_rt    = '0;
    wr_id_rs = '0;
    wr_id_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_id_rs[k] = v_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == id_rs);
      wr_id_rt[k] = v_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == id_rt);
      if (k >= 1) begin
        wr_rs[k] = v_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rs_p0);
        wr_rt[k] = v_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rt_p0);
      end
    end
  end

  // EX bypass: descending scan so the youngest matching writer is the one left selected.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (v_q[0] && wr_rs[k]) fwd_rs_sel = SW'(k);
      if (v_q[0] && wr_rt[k]) fwd_rt_sel = SW'(k);
    end
    fwd_rs_data = (fwd_rs_sel == '0) ? rf_rs : stage_result[int'(fwd_rs_sel)*DW +: DW];
    fwd_rt_data = (fwd_rt_sel == '0) ? rf_rt : stage_result[int'(fwd_rt_sel)*DW +: DW];
    fwd_any     = (fwd_rs_sel != '0) || (fwd_rt_sel != '0);
  end

  // A source is hazardous only if its youngest writer is a load that will not yet be forwardable.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (wr_id_rs[k]) rs_haz = mr_q[k] && (k + 1 < LOAD_STAGE);
      if (wr_id_rt[k]) rt_haz = mr_q[k] && (k + 1 < LOAD_STAGE);
    end
    rs_haz = rs_haz && id_rs_used;
    rt_haz = rt_haz && id_rt_used;
    stall  = id_valid && !flush &&
             (rs_haz || (rt_haz && !((MEM_MEM != 0) && id_memwrite)));
    issue  = id_valid && !stall && !flush;
  end

  generate
    if (DEPTH >= 3) begin : g_mem_mem
      assign fwd_mem_rt = (MEM_MEM != 0) && v_q[1] && mw_p1 && v_q[2] && rw_q[2] &&
                          (rd_q[2] != '0) && (rd_q[2] == rt_p1);
    end else begin : g_no_mem_mem
      assign fwd_mem_rt = 1'b0;
    end
  endgenerate

  // Stage boundary: ID -> EX -> MEM -> ... valid bits and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      v_q <= {v_q[DEPTH-2:0], issue};
      if (stall)   stall_count <= sat_inc(stall_count);
      if (fwd_any) fwd_count   <= sat_inc(fwd_count);
    end
  end

  // Stage boundary: entry payload, qualified by v_q downstream.
  always_ff @(posedge clk) begin
    rw_q     <= {rw_q[DEPTH-2:0], id_regwrite};
    mr_q     <= {mr_q[DEPTH-2:0], id_memread};
    rd_q[0]  <= id_rd;
    for (int k = 1; k < DEPTH; k++) rd_q[k] <= rd_q[k-1];
    rs_p0    <= id_rs;
    rt_p0    <= id_rt;
    rt_p1    <= rt_p0;
    mw_p0    <= id_memwrite;
    mw_p1    <= mw_p0;
  end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: directed scenarios plus random ID traffic against an
// age-indexed in-flight instruction model.
module tb_hazard_fwd_scoreboard;
  localparam int AW = 4, DW = 16, DEPTH = 3, LOAD_STAGE = 2, MEM_MEM = 1, DD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_memwrite, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DEPTH*DW-1:0] stage_result;
  logic [DD*DW-1:0] stage_result_dp;
  logic [DW-1:0] rf_rs, rf_rt;

  logic stall, fwd_mem_rt;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [DW-1:0] fwd_rs_data, fwd_rt_data;
  logic [15:0] stall_count, fwd_count;

  logic m0_stall, m0_mem_rt;
  logic [1:0] m0_rs_sel, m0_rt_sel;
  logic [DW-1:0] m0_rs_data, m0_rt_data;
  logic [15:0] m0_stall_count, m0_fwd_count;

  logic dp_stall, dp_mem_rt;
  logic [3:0] dp_rs_sel, dp_rt_sel;
  logic [DW-1:0] dp_rs_data, dp_rt_data;
  logic [15:0] dp_stall_count, dp_fwd_count;

  hazard_fwd_scoreboard #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .MEM_MEM(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .stage_result(stage_result),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data), .fwd_mem_rt(fwd_mem_rt),
    .stall_count(stall_count), .fwd_count(fwd_count));

  hazard_fwd_scoreboard #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .MEM_MEM(0)) u_dut_m0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .stage_result(stage_result),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .stall(m0_stall), .fwd_rs_sel(m0_rs_sel), .fwd_rt_sel(m0_rt_sel),
    .fwd_rs_data(m0_rs_data), .fwd_rt_data(m0_rt_data), .fwd_mem_rt(m0_mem_rt),
    .stall_count(m0_stall_count), .fwd_count(m0_fwd_count));

  hazard_fwd_scoreboard #(.AW(AW), .DW(DW), .DEPTH(DD), .LOAD_STAGE(15), .MEM_MEM(1)) u_dut_dp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .stage_result(stage_result_dp),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .stall(dp_stall), .fwd_rs_sel(dp_rs_sel), .fwd_rt_sel(dp_rt_sel),
    .fwd_rs_data(dp_rs_data), .fwd_rt_data(dp_rt_data), .fwd_mem_rt(dp_mem_rt),
    .stall_count(dp_stall_count), .fwd_count(dp_fwd_count));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic v, rw, mr, mw;
    logic [AW-1:0] rd, rs, rt;
  } instr_t;

  // fl[a] = instruction issued a+1 cycles ago (a = 0 is the one now in EX).
  instr_t fl [DEPTH];
  int m_stall_cnt, m_fwd_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic rsu, input logic rtu,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_used = rsu; id_rt_used = rtu;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int youngest(input logic [AW-1:0] r, input int from);
    for (int a = from; a < DEPTH; a++)
      if (fl[a].v && fl[a].rw && fl[a].rd == r && r != 0) return a;
    return -1;
  endfunction

  task automatic test_reset();
    rf_rs = 16'hAAAA; rf_rt = 16'h5555; stage_result = '0;
    do_reset();
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd0) begin n_bad++; $display("FAIL reset_rs_sel: got %0d want 0", fwd_rs_sel); end
    n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL reset_rt_sel: got %0d want 0", fwd_rt_sel); end
    n_cmp++; if (fwd_rs_data !== 16'hAAAA) begin n_bad++; $display("FAIL reset_rs_data: got %h want aaaa", fwd_rs_data); end
    n_cmp++; if (fwd_rt_data !== 16'h5555) begin n_bad++; $display("FAIL reset_rt_data: got %h want 5555", fwd_rt_data); end
    n_cmp++; if (fwd_mem_rt !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rt: got %0b want 0", fwd_mem_rt); end
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    n_cmp++; if (fwd_count !== 16'd0) begin n_bad++; $display("FAIL reset_fwd_count: got %0d want 0", fwd_count); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 4'd1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    stage_result = {16'h0000, 16'h1234, 16'h0000}; rf_rt = 16'h7777;
    @(negedge clk);
    n_cmp++; if (fwd_rs_sel !== 2'd1) begin n_bad++; $display("FAIL fwd_rs_sel: got %0d want 1", fwd_rs_sel); end
    n_cmp++; if (fwd_rs_data !== 16'h1234) begin n_bad++; $display("FAIL fwd_rs_data: got %h want 1234", fwd_rs_data); end
    n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL fwd_rt_sel: got %0d want 0", fwd_rt_sel); end
    n_cmp++; if (fwd_rt_data !== 16'h7777) begin n_bad++; $display("FAIL fwd_rt_data: got %h want 7777", fwd_rt_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (fwd_count !== 16'd1) begin n_bad++; $display("FAIL fwd_count: got %0d want 1", fwd_count); end
  endtask

  task automatic test_youngest();
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 4'd3, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    stage_result = {16'h0001, 16'h0002, 16'hDEAD};
    @(negedge clk);
    n_cmp++; if (fwd_rs_sel !== 2'd1) begin n_bad++; $display("FAIL youngest_sel: got %0d want 1", fwd_rs_sel); end
    n_cmp++; if (fwd_rs_data !== 16'h0002) begin n_bad++; $display("FAIL youngest_data: got %h want 0002", fwd_rs_data); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd5, 4'd4, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got %0b want 1", stall); end
    tick();
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd0) begin n_bad++; $display("FAIL load_use_bubble_sel: got %0d want 0", fwd_rs_sel); end
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
    tick();
    idle();
    stage_result = {16'hBEEF, 16'h1111, 16'h0000};
    @(negedge clk);
    n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL load_use_sel: got %0d want 2", fwd_rs_sel); end
    n_cmp++; if (fwd_rs_data !== 16'hBEEF) begin n_bad++; $display("FAIL load_use_data: got %h want beef", fwd_rs_data); end
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL load_use_count_hold: got %0d want 1", stall_count); end
  endtask

  task automatic test_mem_mem();
    do_reset();
    set_id(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL memmem_no_stall: got %0b want 0", stall); end
    n_cmp++; if (m0_stall !== 1'b1) begin n_bad++; $display("FAIL memmem_off_stall: got %0b want 1", m0_stall); end
    tick();
    @(negedge clk);
    n_cmp++; if (m0_stall !== 1'b0) begin n_bad++; $display("FAIL memmem_off_release: got %0b want 0", m0_stall); end
    n_cmp++; if (fwd_mem_rt !== 1'b0) begin n_bad++; $display("FAIL memmem_early: got %0b want 0", fwd_mem_rt); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (fwd_mem_rt !== 1'b1) begin n_bad++; $display("FAIL memmem_bypass: got %0b want 1", fwd_mem_rt); end
  endtask

  task automatic test_r0_flush();
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    rf_rs = 16'h5A5A;
    @(negedge clk);
    n_cmp++; if (fwd_rs_sel !== 2'd0) begin n_bad++; $display("FAIL r0_sel: got %0d want 0", fwd_rs_sel); end
    n_cmp++; if (fwd_rs_data !== 16'h5A5A) begin n_bad++; $display("FAIL r0_data: got %h want 5a5a", fwd_rs_data); end
    set_id(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd2, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall: got %0b want 1", stall); end
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", stall_count); end
    n_cmp++; if (fwd_rs_sel !== 2'd0) begin n_bad++; $display("FAIL flush_bubble: got %0d want 0", fwd_rs_sel); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd5, 4'd4, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %0b want 1", stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL midrst_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    n_cmp++; if (stall_count !== 16'd0 || fwd_count !== 16'd0) begin n_bad++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", stall_count, fwd_count); end
  endtask

  // Deep instance: each load keeps a dependent stalled 14 cycles, giving long stall runs.
  task automatic test_saturation();
    do_reset();
    for (int p = 1; p <= 4683; p++) begin
      set_id(1'b1, 4'd1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (14) tick();
      if (p == 1) begin
        @(negedge clk);
        n_cmp++; if (dp_stall_count !== 16'd14) begin n_bad++; $display("FAIL sat_first: got %0d want 14", dp_stall_count); end
        n_cmp++; if (dp_stall !== 1'b0) begin n_bad++; $display("FAIL sat_release: got %0b want 0", dp_stall); end
      end
      if (p == 4680) begin
        @(negedge clk);
        n_cmp++; if (dp_stall_count !== 16'd65520) begin n_bad++; $display("FAIL sat_near: got %0d want 65520", dp_stall_count); end
      end
      if (p >= 4682) begin
        @(negedge clk);
        n_cmp++; if (dp_stall_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", dp_stall_count); end
      end
    end
  endtask

  task automatic test_random();
    int a_rs, a_rt, s_rs, s_rt, kind;
    logic haz_rs, haz_rt, p_stall, p_mem, iss;
    logic [DW-1:0] p_rs_data, p_rt_data;
    do_reset();
    for (int a = 0; a < DEPTH; a++) fl[a] = '0;
    m_stall_cnt = 0; m_fwd_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      kind = int'($urandom_range(0, 3));
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             kind <= 1, kind == 1, kind == 2);
      flush = ($urandom_range(0, 7) == 0);
      stage_result = {16'($urandom), 16'($urandom), 16'($urandom)};
      rf_rs = 16'($urandom); rf_rt = 16'($urandom);
      @(negedge clk);
      a_rs = id_rs_used ? youngest(id_rs, 0) : -1;
      a_rt = id_rt_used ? youngest(id_rt, 0) : -1;
      haz_rs = (a_rs >= 0) && fl[a_rs].mr && (a_rs + 1 < LOAD_STAGE);
      haz_rt = (a_rt >= 0) && fl[a_rt].mr && (a_rt + 1 < LOAD_STAGE);
      p_stall = id_valid && !flush && (haz_rs || (haz_rt && !(MEM_MEM != 0 && id_memwrite)));
      s_rs = fl[0].v ? youngest(fl[0].rs, 1) : 0;
      s_rt = fl[0].v ? youngest(fl[0].rt, 1) : 0;
      if (s_rs < 0) s_rs = 0;
      if (s_rt < 0) s_rt = 0;
      p_rs_data = (s_rs == 0) ? rf_rs : stage_result[s_rs*DW +: DW];
      p_rt_data = (s_rt == 0) ? rf_rt : stage_result[s_rt*DW +: DW];
      p_mem = fl[1].v && fl[1].mw && fl[2].v && fl[2].rw && fl[2].rd != 0 && fl[2].rd == fl[1].rt;
      n_cmp++; if (stall !== p_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %0b want %0b", c, stall, p_stall); end
      n_cmp++; if (fwd_rs_sel !== 2'(s_rs)) begin n_bad++; $display("FAIL rnd_rs_sel c%0d: got %0d want %0d", c, fwd_rs_sel, s_rs); end
      n_cmp++; if (fwd_rt_sel !== 2'(s_rt)) begin n_bad++; $display("FAIL rnd_rt_sel c%0d: got %0d want %0d", c, fwd_rt_sel, s_rt); end
      n_cmp++; if (fwd_rs_data !== p_rs_data) begin n_bad++; $display("FAIL rnd_rs_data c%0d: got %h want %h", c, fwd_rs_data, p_rs_data); end
      n_cmp++; if (fwd_rt_data !== p_rt_data) begin n_bad++; $display("FAIL rnd_rt_data c%0d: got %h want %h", c, fwd_rt_data, p_rt_data); end
      n_cmp++; if (fwd_mem_rt !== p_mem) begin n_bad++; $display("FAIL rnd_mem_rt c%0d: got %0b want %0b", c, fwd_mem_rt, p_mem); end
      n_cmp++; if (stall_count !== 16'(m_stall_cnt)) begin n_bad++; $display("FAIL rnd_stall_count c%0d: got %0d want %0d", c, stall_count, m_stall_cnt); end
      n_cmp++; if (fwd_count !== 16'(m_fwd_cnt)) begin n_bad++; $display("FAIL rnd_fwd_count c%0d: got %0d want %0d", c, fwd_count, m_fwd_cnt); end
      iss = id_valid && !p_stall && !flush;
      for (int a = DEPTH - 1; a >= 1; a--) fl[a] = fl[a-1];
      fl[0] = iss ? {1'b1, id_regwrite, id_memread, id_memwrite, id_rd, id_rs, id_rt} : '0;
      if (p_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if ((s_rs != 0 || s_rt != 0) && m_fwd_cnt < 65535) m_fwd_cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    stage_result = '0; stage_result_dp = '0; rf_rs = '0; rf_rt = '0;
    test_reset();
    test_forward();
    test_youngest();
    test_load_use();
    test_mem_mem();
    test_r0_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
